// File: rtl/data_path_if.sv
// data_path_if: bundles the controller-facing signals of data_path.
//   in       - external load data (controller -> datapath)
//   reg_addr - destination register index for this cycle's write
//   s_reg    - write-source select: 1 = in, 0 = ALU result
//   s        - ALU op: 0 = add, 1 = subtract
//   out      - combinational ALU result (datapath -> controller)
//   cout     - combinational ALU carry-out / no-borrow flag
//   zero     - (out == 0), present only when DATA_PATH_ZERO_FLAG_EN is defined
// Modports: master (controller side), slave (datapath side).
interface data_path_if #(
    parameter int unsigned BIT_WIDTH = 4
);
    logic [BIT_WIDTH-1:0] in;
    logic [1:0]           reg_addr;
    logic                 s_reg;
    logic                 s;
    logic [BIT_WIDTH-1:0] out;
    logic                 cout;
`ifdef DATA_PATH_ZERO_FLAG_EN
    logic                 zero;
`endif

    modport master (
        output in,
        output reg_addr,
        output s_reg,
        output s,
`ifdef DATA_PATH_ZERO_FLAG_EN
        input  zero,
`endif
        input  out,
        input  cout
    );

    modport slave (
        input  in,
        input  reg_addr,
        input  s_reg,
        input  s,
`ifdef DATA_PATH_ZERO_FLAG_EN
        output zero,
`endif
        output out,
        output cout
    );
endinterface

// File: rtl/data_path.sv
// data_path: 4-entry register file (R0..R3) with an add/subtract ALU on R0 and R1.
// Every rising clock edge writes R[reg_addr] with either the external input or the
// ALU result; there is no write enable.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset, clears R0..R3
//   dp_io  - data_path_if.slave: in, reg_addr, s_reg, s -> out, cout (and zero)
// Optional feature: define DATA_PATH_ZERO_FLAG_EN to add the zero output (out == 0).
module data_path #(
    parameter int unsigned BIT_WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    data_path_if.slave     dp_io
);

    logic [BIT_WIDTH-1:0] regs_q [4];
    logic [BIT_WIDTH-1:0] regs_d [4];
    logic [BIT_WIDTH-1:0] alu_b;
    logic [BIT_WIDTH:0]   alu_sum;

    // Subtract as R0 + ~R1 + 1 so cout reads as "no borrow".
    always_comb begin
        alu_b   = dp_io.s ? ~regs_q[1] : regs_q[1];
        alu_sum = {1'b0, regs_q[0]} + {1'b0, alu_b} + {{BIT_WIDTH{1'b0}}, dp_io.s};
    end

    assign dp_io.out  = alu_sum[BIT_WIDTH-1:0];
    assign dp_io.cout = alu_sum[BIT_WIDTH];

`ifdef DATA_PATH_ZERO_FLAG_EN
    assign dp_io.zero = (alu_sum[BIT_WIDTH-1:0] == '0);
`endif

    // Next state reads the pre-edge registers, so R0 <= R0 + R1 is well defined.
    always_comb begin
        regs_d = regs_q;
        regs_d[dp_io.reg_addr] = dp_io.s_reg ? dp_io.in : alu_sum[BIT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed self-checking bench for data_path.
module tb_data_path;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    data_path_if #(.BIT_WIDTH(4)) dp ();

    data_path #(.BIT_WIDTH(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dp_io (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Harmless filler write: load into R3, which never reaches the ALU.
    task automatic idle();
        dp.s_reg    = 1'b1;
        dp.reg_addr = 2'd3;
        dp.in       = 4'd0;
    endtask

    task automatic load(input logic [1:0] a, input logic [3:0] v);
        @(negedge clk);
        dp.s_reg    = 1'b1;
        dp.reg_addr = a;
        dp.in       = v;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic alu_wr(input logic [1:0] a, input logic op);
        @(negedge clk);
        dp.s_reg    = 1'b0;
        dp.reg_addr = a;
        dp.s        = op;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic check(input string tag, input logic op, input logic [3:0] eo,
                         input logic ec);
        dp.s = op;
        #1;
        n_cmp++;
        assert (dp.out === eo) else begin
            n_err++;
            $error("FAIL %s out: got %0d want %0d", tag, dp.out, eo);
        end
        n_cmp++;
        assert (dp.cout === ec) else begin
            n_err++;
            $error("FAIL %s cout: got %0b want %0b", tag, dp.cout, ec);
        end
`ifdef DATA_PATH_ZERO_FLAG_EN
        n_cmp++;
        assert (dp.zero === (eo == 4'd0)) else begin
            n_err++;
            $error("FAIL %s zero: got %0b want %0b", tag, dp.zero, (eo == 4'd0));
        end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        dp.s  = 1'b0;
        idle();
        #12;
        check("reset_add", 1'b0, 4'd0, 1'b0);
        check("reset_sub", 1'b1, 4'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Load R0=4, R1=3
        load(2'd0, 4'd4);
        load(2'd1, 4'd3);
        check("load_add", 1'b0, 4'd7, 1'b0);
        check("load_sub", 1'b1, 4'd1, 1'b1);

        // Swap via add/sub sequence
        alu_wr(2'd0, 1'b0);
        check("swap1_add", 1'b0, 4'd10, 1'b0);
        alu_wr(2'd1, 1'b1);
        check("swap2_sub", 1'b1, 4'd3, 1'b1);
        alu_wr(2'd0, 1'b1);
        check("swap_final_add", 1'b0, 4'd7, 1'b0);
        check("swap_final_sub", 1'b1, 4'd15, 1'b0);

        // Overflow and borrow
        load(2'd0, 4'd15);
        load(2'd1, 4'd1);
        check("overflow_add", 1'b0, 4'd0, 1'b1);
        load(2'd0, 4'd1);
        load(2'd1, 4'd3);
        check("borrow_sub", 1'b1, 4'd14, 1'b0);

        // R2/R3 do not affect the ALU
        load(2'd2, 4'd9);
        load(2'd3, 4'd5);
        check("r23_sub", 1'b1, 4'd14, 1'b0);
        check("r23_add", 1'b0, 4'd4, 1'b0);
        load(2'd0, 4'd2);
        load(2'd1, 4'd2);
        check("equal_sub", 1'b1, 4'd0, 1'b1);

        // s unknown while loading from in
        @(negedge clk);
        dp.s_reg    = 1'b1;
        dp.reg_addr = 2'd1;
        dp.in       = 4'd6;
        dp.s        = 1'bx;
        @(posedge clk);
        #1;
        idle();
        check("xs_add", 1'b0, 4'd8, 1'b0);
        check("xs_sub", 1'b1, 4'd12, 1'b0);

        // Mid-cycle asynchronous reset with nonzero registers
        #2;
        rst_n = 1'b0;
        check("async_rst_add", 1'b0, 4'd0, 1'b0);
        check("async_rst_sub", 1'b1, 4'd0, 1'b1);
        // Held in reset across an edge: the load must not land
        load(2'd0, 4'd9);
        check("held_rst_add", 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        load(2'd0, 4'd5);
        load(2'd1, 4'd2);
        check("post_rst_add", 1'b0, 4'd7, 1'b0);
        check("post_rst_sub", 1'b1, 4'd3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
